alu_exec: RTL and testbench

Execute stage directly downstream of the ALU opcode decoder. Accepts a decoded 4-bit ALU operation, immediate-select and decode-error flag with operands over a valid/ready handshake, computes the result, and holds it in an output register under backpressure. Most operations complete in one cycle. Shifts run iteratively at one bit per cycle, which bounds shifter area.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_exec_if.sv | 29 ++
 rtl/alu_exec_shifter.sv | 53 +++++
 rtl/alu_exec.sv | 153 +++++++++++++++
 tb/tb_alu_exec.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU opcode decoder and the alu_exec stage.
package alu_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_NOT  = 4'b0101,
      OP_CLR  = 4'b0110,
      OP_CMPE = 4'b0111,
      OP_CMPG = 4'b1000,
      OP_CMPL = 4'b1001,
      OP_SHRA = 4'b1010,
      OP_SHRL = 4'b1011,
      OP_SHL  = 4'b1100,
      OP_JMPI = 4'b1101,
      OP_NOP  = 4'b1111
   } alu_op_t;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } exec_state_t;

   function automatic logic is_shift(alu_op_t op);
      return (op == OP_SHRA) || (op == OP_SHRL) || (op == OP_SHL);
   endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Upstream operation handshake and downstream result bus of the execute stage.
interface alu_exec_if import alu_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        alu_op;
   logic              imm_sel;
   logic              dec_err;
   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] src_b;
   logic [DATA_W-1:0] imm;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] result;
   logic              cmp_flag;
   logic              jump;
   logic              err_out;

   modport master (
      output in_valid, alu_op, imm_sel, dec_err, src_a, src_b, imm, out_ready,
      input  in_ready, out_valid, result, cmp_flag, jump, err_out
   );

   modport slave (
      input  in_valid, alu_op, imm_sel, dec_err, src_a, src_b, imm, out_ready,
      output in_ready, out_valid, result, cmp_flag, jump, err_out
   );
endinterface

// File: rtl/alu_exec_shifter.sv
// Iterative shifter: one bit per step, so only a 1-bit shift mux is needed.
module alu_exec_shifter import alu_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int SH_W   = $clog2(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              i_load,
   input  logic              i_step,
   input  alu_op_t           i_op,
   input  logic [DATA_W-1:0] i_val,
   input  logic [SH_W-1:0]   i_amt,
   output logic [DATA_W-1:0] o_next,
   output logic              o_done
);
   logic [DATA_W-1:0] r_work;
   logic [SH_W-1:0]   r_cnt;
   logic              r_left;
   logic              r_arith;

   // Working register, remaining count and direction/fill captured at load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_work  <= {DATA_W{1'b0}};
         r_cnt   <= {SH_W{1'b0}};
         r_left  <= 1'b0;
         r_arith <= 1'b0;
      end else if (flush) begin
         r_cnt   <= {SH_W{1'b0}};
      end else if (i_load) begin
         r_work  <= i_val;
         r_cnt   <= i_amt;
         r_left  <= (i_op == OP_SHL);
         r_arith <= (i_op == OP_SHRA);
      end else if (i_step) begin
         r_work  <= o_next;
         r_cnt   <= r_cnt - SH_W'(1'b1);
      end
   end

   // Single-bit shift of the working register.
   always_comb begin
      o_next = r_work;
      if (r_left) begin
         o_next = {r_work[DATA_W-2:0], 1'b0};
      end else begin
         o_next = {r_arith & r_work[DATA_W-1], r_work[DATA_W-1:1]};
      end
   end

   assign o_done = i_step && (r_cnt == SH_W'(1'b1));
endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: single-cycle ALU, iterative shifts, held output register.
module alu_exec import alu_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   alu_exec_if.slave  bus
);
   localparam int SH_W = $clog2(DATA_W);

   exec_state_t       r_state;
   exec_state_t       w_state_nxt;
   alu_op_t           w_op;
   logic [DATA_W-1:0] w_b;
   logic [SH_W-1:0]   w_amt;
   logic [DATA_W-1:0] w_res;
   logic              w_cmp;
   logic              w_jmp;
   logic              w_err;
   logic              w_in_ready;
   logic              w_accept;
   logic              w_sh_start;
   logic              w_alu_load;
   logic              w_sh_step;
   logic              w_sh_done;
   logic [DATA_W-1:0] w_sh_next;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_result;
   logic              r_cmp_flag;
   logic              r_jump;
   logic              r_err_out;

   assign w_op  = alu_op_t'(bus.alu_op);
   assign w_b   = bus.imm_sel ? bus.imm : bus.src_b;
   assign w_amt = w_b[SH_W-1:0];

   // Single-cycle ALU; a shift result here only matters for amount 0.
   always_comb begin
      w_res = {DATA_W{1'b0}};
      w_cmp = 1'b0;
      w_jmp = 1'b0;
      w_err = 1'b0;
      case (w_op)
         OP_ADD:  w_res = bus.src_a + w_b;
         OP_SUB:  w_res = bus.src_a - w_b;
         OP_AND:  w_res = bus.src_a & w_b;
         OP_OR:   w_res = bus.src_a | w_b;
         OP_XOR:  w_res = bus.src_a ^ w_b;
         OP_NOT:  w_res = ~bus.src_a;
         OP_CMPE: w_cmp = (bus.src_a == w_b);
         OP_CMPG: w_cmp = ($signed(bus.src_a) > $signed(w_b));
         OP_CMPL: w_cmp = ($signed(bus.src_a) < $signed(w_b));
         OP_SHRA, OP_SHRL, OP_SHL: w_res = bus.src_a;
         OP_JMPI: begin
            w_res = w_b;
            w_jmp = 1'b1;
         end
         default: w_res = {DATA_W{1'b0}};
      endcase
      if (bus.dec_err) begin
         w_res = {DATA_W{1'b0}};
         w_cmp = 1'b0;
         w_jmp = 1'b0;
         w_err = 1'b1;
      end else begin
         w_res[0] = w_res[0] | w_cmp;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic; flush overrides and aborts any shift.
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  w_state_nxt = w_sh_start ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: w_state_nxt = w_sh_done ? ST_IDLE : ST_SHIFT;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // FSM outputs: handshake and load strobes.
   always_comb begin
      w_in_ready = (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready) && !flush;
      w_accept   = bus.in_valid && w_in_ready;
      w_sh_start = w_accept && is_shift(w_op) && !bus.dec_err && (w_amt != {SH_W{1'b0}});
      w_alu_load = w_accept && !w_sh_start;
      w_sh_step  = (r_state == ST_SHIFT) && !flush;
   end

   alu_exec_shifter #(.DATA_W(DATA_W), .SH_W(SH_W)) u_shifter (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .i_load (w_sh_start),
      .i_step (w_sh_step),
      .i_op   (w_op),
      .i_val  (bus.src_a),
      .i_amt  (w_amt),
      .o_next (w_sh_next),
      .o_done (w_sh_done)
   );

   // Output register; only reloaded when free, so it holds under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_result    <= {DATA_W{1'b0}};
         r_cmp_flag  <= 1'b0;
         r_jump      <= 1'b0;
         r_err_out   <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
         r_result    <= {DATA_W{1'b0}};
         r_cmp_flag  <= 1'b0;
         r_jump      <= 1'b0;
         r_err_out   <= 1'b0;
      end else if (w_alu_load) begin
         r_out_valid <= 1'b1;
         r_result    <= w_res;
         r_cmp_flag  <= w_cmp;
         r_jump      <= w_jmp;
         r_err_out   <= w_err;
      end else if (w_sh_done) begin
         r_out_valid <= 1'b1;
         r_result    <= w_sh_next;
         r_cmp_flag  <= 1'b0;
         r_jump      <= 1'b0;
         r_err_out   <= 1'b0;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.cmp_flag  = r_cmp_flag;
   assign bus.jump      = r_jump;
   assign bus.err_out   = r_err_out;
endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec with hand-computed expectations.
module tb_alu_exec;
   import alu_pkg::*;

   logic clk;
   logic rst_n;
   logic flush;
   int   n_checks;
   int   n_fail;

   alu_exec_if #(.DATA_W(32)) bus ();

   alu_exec #(.DATA_W(32)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; presents the op and returns just after the accept edge.
   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic isel, input logic [31:0] im, input logic derr);
      int w;
      bus.alu_op   = op;
      bus.src_a    = a;
      bus.src_b    = b;
      bus.imm_sel  = isel;
      bus.imm      = im;
      bus.dec_err  = derr;
      bus.in_valid = 1'b1;
      #1;
      w = 0;
      while (!bus.in_ready && w < 64) begin
         @(negedge clk);
         w++;
      end
      chk("accept", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.dec_err  = 1'b0;
      bus.imm_sel  = 1'b0;
   endtask

   task automatic run_alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic isel, input logic [31:0] im,
                          input logic derr, input logic [31:0] e_res, input logic e_cmp,
                          input logic e_jmp, input logic e_err);
      send(op, a, b, isel, im, derr);
      @(negedge clk);
      chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, "_res"}, bus.result, e_res);
      chk({tag, "_cmp"}, {31'd0, bus.cmp_flag}, {31'd0, e_cmp});
      chk({tag, "_jmp"}, {31'd0, bus.jump}, {31'd0, e_jmp});
      chk({tag, "_err"}, {31'd0, bus.err_out}, {31'd0, e_err});
   endtask

   // e_low is the number of sampled cycles with in_ready low before the result appears.
   task automatic run_shift(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] e_res, input int e_low);
      int low;
      send(op, a, b, 1'b0, 32'd0, 1'b0);
      low = 0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (!bus.in_ready) low++;
         if (bus.out_valid) break;
      end
      chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({tag, "_res"}, bus.result, e_res);
      chk({tag, "_busy"}, low, e_low);
      chk({tag, "_cmp"}, {31'd0, bus.cmp_flag}, 32'd0);
   endtask

   initial begin
      int seen;
      n_checks      = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.alu_op    = 4'd0;
      bus.imm_sel   = 1'b0;
      bus.dec_err   = 1'b0;
      bus.src_a     = 32'd0;
      bus.src_b     = 32'd0;
      bus.imm       = 32'd0;
      bus.out_ready = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_res", bus.result, 32'd0);
      chk("rst_flags", {29'd0, bus.cmp_flag, bus.jump, bus.err_out}, 32'd0);
      rst_n = 1'b1;
      flush = 1'b1;
      #1;
      chk("rdy_flush", {31'd0, bus.in_ready}, 32'd0);
      flush = 1'b0;
      #1;
      chk("rdy_idle", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      bus.out_ready = 1'b1;

      run_alu("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      run_alu("add_imm", OP_ADD, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'd5, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
      run_alu("sub", OP_SUB, 32'd0, 32'd1, 1'b0, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      run_alu("and", OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'd0, 1'b0, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
      run_alu("or", OP_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'd0, 1'b0, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
      run_alu("xor", OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'd0, 1'b0, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0);
      run_alu("not", OP_NOT, 32'hF0F0_F0F0, 32'd9, 1'b0, 32'd0, 1'b0, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0);
      run_alu("clr", OP_CLR, 32'h1234_5678, 32'd9, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      run_alu("cmpl", OP_CMPL, 32'hFFFF_FFFE, 32'd3, 1'b0, 32'd0, 1'b0, 32'd1, 1'b1, 1'b0, 1'b0);
      run_alu("cmpg", OP_CMPG, 32'hFFFF_FFFE, 32'd3, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      run_alu("cmpe", OP_CMPE, 32'd7, 32'd7, 1'b0, 32'd0, 1'b0, 32'd1, 1'b1, 1'b0, 1'b0);
      run_alu("cmpg_min", OP_CMPG, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      run_alu("cmpl_min", OP_CMPL, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'd0, 1'b0, 32'd1, 1'b1, 1'b0, 1'b0);
      run_alu("dec_err", OP_ADD, 32'd3, 32'd4, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
      run_alu("dec_err_cmp", OP_CMPE, 32'd7, 32'd7, 1'b0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);
      run_alu("nop", OP_NOP, 32'h55, 32'h66, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      run_alu("op1110", 4'b1110, 32'h55, 32'h66, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);

      run_shift("shra4", OP_SHRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 4);
      run_shift("shl0", OP_SHL, 32'h1234_ABCD, 32'd0, 32'h1234_ABCD, 0);
      run_shift("shrl_hi", OP_SHRL, 32'hF000_0000, 32'h0000_0024, 32'h0F00_0000, 4);
      run_shift("shl31", OP_SHL, 32'd1, 32'd31, 32'h8000_0000, 31);
      run_shift("shra1_pos", OP_SHRA, 32'h7000_0000, 32'd1, 32'h3800_0000, 1);

      send(OP_JMPI, 32'd0, 32'h0000_0100, 1'b0, 32'd0, 1'b0);
      bus.out_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("jmp_hold_res", bus.result, 32'h0000_0100);
         chk("jmp_hold_flags", {29'd0, bus.out_valid, bus.jump, bus.in_ready}, 32'b110);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("jmp_release_rdy", {31'd0, bus.in_ready}, 32'd1);
      run_alu("after_jmp", OP_ADD, 32'd1, 32'd1, 1'b0, 32'd0, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);

      send(OP_SHL, 32'd1, 32'd10, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk("flush_rdy", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("flush_idle", {31'd0, bus.in_ready}, 32'd1);
      seen = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      chk("flush_no_out", seen, 0);

      send(OP_SHL, 32'd1, 32'd10, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstmid_valid", {31'd0, bus.out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rstmid_idle", {31'd0, bus.in_ready}, 32'd1);
      seen = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (bus.out_valid) seen++;
      end
      chk("rstmid_no_out", seen, 0);
      run_alu("post_rst", OP_ADD, 32'd5, 32'd6, 1'b0, 32'd0, 1'b0, 32'd11, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
